// File: rtl/run_ctrl_pkg.sv
// run_ctrl shared types and defaults.
// State encoding for the run FSM and the default halt address.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESET   = 3'd1,
        S_RUN     = 3'd2,
        S_STEP    = 3'd3,
        S_PAUSE   = 3'd4,
        S_DONE    = 3'd5,
        S_TIMEOUT = 3'd6
    } state_t;

    localparam logic [31:0] DEF_HALT_ADDR = 32'h0000_00FC;

endpackage

// File: rtl/run_ctrl_if.sv
// Board-facing control and status bundle of the run controller.
// master = board/debugger side, slave = run_ctrl.
interface run_ctrl_if #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16,
    parameter int NUM_BP    = 2
);
    logic                       start;
    logic                       step;
    logic                       resume;
    logic [CNT_WIDTH-1:0]       max_cycles;
    logic [NUM_BP*PC_WIDTH-1:0] bp_addr;
    logic [NUM_BP-1:0]          bp_en;
    logic [CNT_WIDTH-1:0]       cycle_count;
    logic [NUM_BP-1:0]          bp_hit;
    logic [PC_WIDTH-1:0]        halt_pc;
    logic                       done;
    logic                       timeout;
    logic                       paused;

    modport master (
        output start, step, resume, max_cycles, bp_addr, bp_en,
        input  cycle_count, bp_hit, halt_pc, done, timeout, paused
    );

    modport slave (
        input  start, step, resume, max_cycles, bp_addr, bp_en,
        output cycle_count, bp_hit, halt_pc, done, timeout, paused
    );
endinterface

// File: rtl/run_ctrl_bp_match.sv
// Breakpoint comparators: one enabled equality compare per slot.
// Produces the per-slot hit vector and its OR.
module bp_match
    import run_ctrl_pkg::*;
#(
    parameter int PC_WIDTH = 32,
    parameter int NUM_BP   = 2
) (
    input  logic [PC_WIDTH-1:0]        pc,
    input  logic [NUM_BP*PC_WIDTH-1:0] addr,
    input  logic [NUM_BP-1:0]          en,
    output logic [NUM_BP-1:0]          hit,
    output logic                       any
);

    // Parallel slot compares against the current PC.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            hit[i] = en[i] && (addr[i*PC_WIDTH +: PC_WIDTH] == pc);
        end
        any = |hit;
    end

endmodule

// File: rtl/run_ctrl.sv
// Run controller for the single-cycle MIPS core.
// Gates the core clock enable and reset; breakpoints, step, pause, limits.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int          PC_WIDTH   = 32,
    parameter int          CNT_WIDTH  = 16,
    parameter int          NUM_BP     = 2,
    parameter logic [31:0] HALT_ADDR  = DEF_HALT_ADDR,
    parameter int          RST_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] pc,
    output logic                cpu_en,
    output logic                cpu_reset,
    run_ctrl_if.slave           ctl
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

    state_t                state;
    state_t                state_nx;
    logic [RW-1:0]         rst_cnt;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [NUM_BP-1:0]     hit;
    logic [NUM_BP-1:0]     hit_vec;
    logic [PC_WIDTH-1:0]   stop_pc;
    logic                  hit_any;
    logic                  skip_bp;
    logic                  halt_c;
    logic                  to_c;
    logic                  bp_c;
    logic                  active;
    logic                  accept;

    bp_match #(
        .PC_WIDTH (PC_WIDTH),
        .NUM_BP   (NUM_BP)
    ) u_bp (
        .pc   (pc),
        .addr (ctl.bp_addr),
        .en   (ctl.bp_en),
        .hit  (hit_vec),
        .any  (hit_any)
    );

    // Stop conditions and the core enable; a stop PC is never executed.
    always_comb begin
        halt_c = (pc == PC_WIDTH'(HALT_ADDR));
        to_c   = (ctl.max_cycles != '0) && (cnt == ctl.max_cycles);
        bp_c   = hit_any && !skip_bp;
        active = (state == S_RUN) || (state == S_STEP);
        cpu_en = active && !(halt_c || to_c || bp_c);
        accept = ctl.start && ((state == S_IDLE) || (state == S_PAUSE) ||
                               (state == S_DONE) || (state == S_TIMEOUT));
    end

    // Next-state logic; start wins over resume/step while paused.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (ctl.start) state_nx = S_RESET;
            S_RESET: if (rst_cnt == RST_LAST) state_nx = S_RUN;
            S_RUN: begin
                if (halt_c)    state_nx = S_DONE;
                else if (to_c) state_nx = S_TIMEOUT;
                else if (bp_c) state_nx = S_PAUSE;
            end
            S_STEP: begin
                if (halt_c)    state_nx = S_DONE;
                else if (to_c) state_nx = S_TIMEOUT;
                else           state_nx = S_PAUSE;
            end
            S_PAUSE: begin
                if (ctl.start)       state_nx = S_RESET;
                else if (ctl.resume) state_nx = S_RUN;
                else if (ctl.step)   state_nx = S_STEP;
            end
            S_DONE, S_TIMEOUT: if (ctl.start) state_nx = S_RESET;
            default: state_nx = S_IDLE;
        endcase
    end

    // State, reset-length counter, cycle counter and stop latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            rst_cnt <= '0;
            cnt     <= '0;
            hit     <= '0;
            stop_pc <= '0;
            skip_bp <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_RESET) rst_cnt <= rst_cnt + RW'(1);
            else                  rst_cnt <= '0;
            if (accept) begin
                cnt     <= '0;
                hit     <= '0;
                stop_pc <= '0;
                skip_bp <= 1'b0;
            end else begin
                if (cpu_en) begin
                    if (cnt != '1) cnt <= cnt + CNT_WIDTH'(1);
                    skip_bp <= 1'b0;
                end
                if (active && !cpu_en) stop_pc <= pc;
                if (state == S_RUN && !halt_c && !to_c && bp_c) hit <= hit_vec;
                if (state == S_STEP) hit <= '0;
                if (state == S_PAUSE && (ctl.resume || ctl.step)) skip_bp <= 1'b1;
            end
        end
    end

    assign cpu_reset       = (state == S_RESET);
    assign ctl.cycle_count = cnt;
    assign ctl.bp_hit      = hit;
    assign ctl.halt_pc     = stop_pc;
    assign ctl.done        = (state == S_DONE);
    assign ctl.timeout     = (state == S_TIMEOUT);
    assign ctl.paused      = (state == S_PAUSE);

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl driving a small PC-sequencing core model.
// Stimulus pushes expected stop/probe snapshots; a negedge monitor compares.
module tb_run_ctrl;

    localparam int PW = 32;
    localparam int CW = 16;
    localparam int NB = 2;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc    = 32'h0;
    logic        cpu_en;
    logic        cpu_reset;

    run_ctrl_if #(.PC_WIDTH(PW), .CNT_WIDTH(CW), .NUM_BP(NB)) ctl ();

    run_ctrl #(
        .PC_WIDTH   (PW),
        .CNT_WIDTH  (CW),
        .NUM_BP     (NB),
        .HALT_ADDR  (32'h0000_00FC),
        .RST_CYCLES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .cpu_en    (cpu_en),
        .cpu_reset (cpu_reset),
        .ctl       (ctl)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  flags;
        logic [15:0] cnt;
        logic [1:0]  hit;
        logic [31:0] hpc;
        bit          chk_en;
        logic        en;
        bit          chk_rst;
        logic        rst;
        bit          chk_pc;
        logic [31:0] pcv;
        bit          chk_n;
        int          en_n;
        int          rst_n;
    } exp_t;

    exp_t sb[$];

    int mode  = 0;
    int inst  = 0;
    int en_n  = 0;
    int rst_n = 0;

    // Program shapes: 0 loop then jump to 0xFC, 1 endless loop, 2 straight line.
    function automatic logic [31:0] next_pc(input logic [31:0] p, input int n, input int m);
        if (m == 0) return (n == 36) ? 32'hFC : ((p == 32'h20) ? 32'h0 : p + 32'd4);
        if (m == 1) return (p == 32'h20) ? 32'h0 : p + 32'd4;
        return p + 32'd4;
    endfunction

    // Core model plus enabled/reset cycle counters cleared on start.
    always @(posedge clk) begin
        if (cpu_reset) begin
            pc   <= 32'h0;
            inst <= 0;
        end else if (cpu_en) begin
            pc   <= next_pc(pc, inst, mode);
            inst <= inst + 1;
        end
        if (ctl.start) begin
            en_n  <= 0;
            rst_n <= 0;
        end else begin
            if (cpu_en)    en_n  <= en_n + 1;
            if (cpu_reset) rst_n <= rst_n + 1;
        end
    end

    int         checks    = 0;
    int         errors    = 0;
    int         probe_req = 0;
    int         probe_ack = 0;
    int         tmo_req   = 0;
    int         tmo_ack   = 0;
    bit         fin_req   = 1'b0;
    logic [2:0] prev      = 3'b000;
    logic [2:0] fl;
    exp_t       e;
    bit         take;

    task automatic cmp(input string nm, input string f, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s.%s got %0h want %0h", nm, f, a, x);
        end
    endtask

    // Monitor: pops one expectation per stop event or requested probe.
    always @(negedge clk) begin
        fl = {ctl.done, ctl.timeout, ctl.paused};
        if (tmo_ack < tmo_req) begin
            checks++;
            errors++;
            $display("FAIL wait_bound got no stop event want stop event");
            tmo_ack++;
        end
        take = 1'b0;
        if (probe_ack < probe_req) begin
            probe_ack++;
            take = 1'b1;
        end else if ((fl !== prev) && (fl != 3'b000)) begin
            take = 1'b1;
        end
        if (take) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event got flags %b want none", fl);
            end else begin
                e = sb.pop_front();
                cmp(e.name, "flags", 32'(fl), 32'(e.flags));
                cmp(e.name, "cycle_count", 32'(ctl.cycle_count), 32'(e.cnt));
                cmp(e.name, "bp_hit", 32'(ctl.bp_hit), 32'(e.hit));
                cmp(e.name, "halt_pc", ctl.halt_pc, e.hpc);
                if (e.chk_en)  cmp(e.name, "cpu_en", 32'(cpu_en), 32'(e.en));
                if (e.chk_rst) cmp(e.name, "cpu_reset", 32'(cpu_reset), 32'(e.rst));
                if (e.chk_pc)  cmp(e.name, "pc", pc, e.pcv);
                if (e.chk_n) begin
                    cmp(e.name, "en_cycles", 32'(en_n), 32'(e.en_n));
                    cmp(e.name, "rst_cycles", 32'(rst_n), 32'(e.rst_n));
                end
            end
        end
        prev <= fl;
        if (fin_req) begin
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL leftover_expectations got %0d want 0", sb.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    function automatic exp_t mk(input string nm, input logic [2:0] f, input logic [15:0] c,
                                input logic [1:0] h, input logic [31:0] hp);
        exp_t x;
        x.name = nm;   x.flags = f;   x.cnt = c;     x.hit = h;   x.hpc = hp;
        x.chk_en = 0;  x.en = 0;      x.chk_rst = 0; x.rst = 0;
        x.chk_pc = 0;  x.pcv = 0;     x.chk_n = 0;   x.en_n = 0;  x.rst_n = 0;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_stop(input int lim);
        for (int i = 0; i < lim; i++) begin
            tick();
            if ({ctl.done, ctl.timeout, ctl.paused} != 3'b000) return;
        end
        tmo_req++;
    endtask

    task automatic do_start();
        ctl.start = 1'b1;
        tick();
        ctl.start = 1'b0;
    endtask

    task automatic push_stop(input string nm, input logic [2:0] f, input logic [15:0] c,
                             input logic [1:0] h, input logic [31:0] hp, input int n);
        exp_t x;
        x = mk(nm, f, c, h, hp);
        x.chk_en = 1;  x.en = 1'b0;
        x.chk_pc = 1;  x.pcv = hp;
        x.chk_n = 1;   x.en_n = n;   x.rst_n = 2;
        sb.push_back(x);
    endtask

    task automatic push_probe(input string nm, input logic [15:0] c, input logic en, input logic rst);
        exp_t x;
        x = mk(nm, 3'b000, c, 2'b00, 32'h0);
        x.chk_en = 1;  x.en = en;
        x.chk_rst = 1; x.rst = rst;
        sb.push_back(x);
        probe_req++;
    endtask

    initial begin
        ctl.start      = 1'b0;
        ctl.step       = 1'b0;
        ctl.resume     = 1'b0;
        ctl.max_cycles = 16'd0;
        ctl.bp_addr    = '0;
        ctl.bp_en      = 2'b00;
        reset          = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        push_probe("reset", 16'd0, 1'b0, 1'b0);

        tick();
        mode = 0;
        ctl.max_cycles = 16'd500;
        push_stop("halt", 3'b100, 16'd37, 2'b00, 32'hFC, 37);
        do_start();
        wait_stop(200);

        tick();
        do_start();
        push_probe("restart", 16'd0, 1'b0, 1'b1);
        push_stop("halt2", 3'b100, 16'd37, 2'b00, 32'hFC, 37);
        wait_stop(200);

        tick();
        mode = 1;
        push_stop("timeout", 3'b010, 16'd500, 2'b00, 32'h14, 500);
        do_start();
        wait_stop(700);

        tick();
        ctl.bp_addr = {32'h200, 32'h10};
        ctl.bp_en   = 2'b01;
        push_stop("bp_pause", 3'b001, 16'd4, 2'b01, 32'h10, 4);
        do_start();
        wait_stop(100);

        push_stop("bp_resume", 3'b001, 16'd13, 2'b01, 32'h10, 13);
        ctl.resume = 1'b1;
        tick();
        ctl.resume = 1'b0;
        wait_stop(100);

        e = mk("bp_step", 3'b001, 16'd14, 2'b00, 32'h10);
        e.chk_en = 1;  e.en = 1'b0;
        e.chk_pc = 1;  e.pcv = 32'h14;
        e.chk_n = 1;   e.en_n = 14;  e.rst_n = 2;
        sb.push_back(e);
        ctl.step = 1'b1;
        tick();
        ctl.step = 1'b0;
        wait_stop(20);

        tick();
        mode = 2;
        ctl.bp_addr = {32'hFC, 32'h200};
        ctl.bp_en   = 2'b11;
        push_stop("prio", 3'b100, 16'd63, 2'b00, 32'hFC, 63);
        do_start();
        wait_stop(200);

        tick();
        mode = 1;
        ctl.max_cycles = 16'd0;
        ctl.bp_en      = 2'b00;
        do_start();
        repeat (65560) tick();
        push_probe("saturate", 16'hFFFF, 1'b1, 1'b0);

        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        push_probe("mid_reset", 16'd0, 1'b0, 1'b0);

        tick();
        fin_req = 1'b1;
        repeat (4) tick();
        $display("FAIL finish_not_reached got running want finished");
        $fatal(1, "monitor did not finish");
    end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Parametrised run controller for the single-cycle MIPS core, promoting the halt-address / max-cycle loop into synthesizable RTL. It sits between the board/top level and `mips_top` and drives the core's clock enable and reset. It adds breakpoints, single-step, pause/resume, a saturating cycle counter and a sticky completion status. The core advances only on cycles where `cpu_en` is 1.

## Interface
- `PC_WIDTH`, 32: width of the watched PC.
- `CNT_WIDTH`, 16: width of the cycle counter and limit.
- `NUM_BP`, 2: number of breakpoint comparators, ≥1.
- `HALT_ADDR`, 32'h000000FC: PC value meaning "program finished" (word 63).
- `RST_CYCLES`, 2: cycles `cpu_reset` is held on start, ≥1.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `reset`  in  1  synchronous, active-high; returns to IDLE and clears all state.
- `start`  in  1  begin or restart a run.
- `step`  in  1  execute one instruction while PAUSE.
- `resume`  in  1  leave PAUSE and continue to RUN.
- `pc`  in  PC_WIDTH  core's current PC (imem address).
- `max_cycles`  in  CNT_WIDTH  enabled-cycle limit; 0 means unlimited.
- `bp_addr`  in  NUM_BP*PC_WIDTH  breakpoint addresses; slot i is `[i*PC_WIDTH +: PC_WIDTH]`.
- `bp_en`  in  NUM_BP  per-slot breakpoint enable.
- `cpu_en`  out  1  core clock enable (combinational).
- `cpu_reset`  out  1  core reset.
- `cycle_count`  out  CNT_WIDTH  number of enabled cycles this run.
- `bp_hit`  out  NUM_BP  slot(s) that caused the current pause.
- `halt_pc`  out  PC_WIDTH  PC at the last stop event.
- `done`, `timeout`, `paused`  out  1 each  status flags.

## Operation
- States:
  - IDLE.
  - RESET: counts `RST_CYCLES`.
  - RUN.
  - STEP: one cycle.
  - PAUSE.
  - DONE and TIMEOUT: sticky.
- `start` is accepted in IDLE, PAUSE, DONE and TIMEOUT; it is ignored in RESET, RUN and STEP. Accepting it clears `cycle_count`, `bp_hit`, `halt_pc` and the flags, then enters RESET.
- RESET: `cpu_reset`=1 for exactly `RST_CYCLES` cycles, then RUN.
- Stop conditions, evaluated on the current `pc` and registered `cycle_count`, in priority order:
  1. halt: `pc==HALT_ADDR`.
  2. timeout: `max_cycles!=0 && cycle_count==max_cycles`.
  3. breakpoint: any `bp_en[i] && pc==bp_addr[i]`, masked by `skip_bp`.
- `cpu_en` = (RUN or STEP) and no stop condition. The instruction at a stop PC is therefore never executed.
- Stop transitions:
  - halt → DONE.
  - timeout → TIMEOUT.
  - breakpoint → PAUSE, latching every matching slot into `bp_hit`.
  - In all three cases `halt_pc` ← `pc`.
- `cycle_count` increments on each cycle with `cpu_en`=1 and saturates at all-ones.
- PAUSE:
  - `resume` → RUN and sets `skip_bp`.
  - `step` → STEP and sets `skip_bp`.
  - If both are asserted, `resume` wins.
  - `skip_bp` clears after the first cycle with `cpu_en`=1.
- STEP: one enabled cycle, then back to PAUSE with `bp_hit` cleared. If a halt or timeout condition is present, STEP goes to DONE or TIMEOUT instead, with no enabled cycle.
- Flags: `done`=DONE, `timeout`=TIMEOUT, `paused`=PAUSE. All are registered state decodes.

## Timing
- Reset values: state IDLE; `cpu_en` 0, `cpu_reset` 0, `cycle_count` 0, `bp_hit` 0, `halt_pc` 0; `done`, `timeout`, `paused` all 0.
- `start` seen at edge N: `cpu_reset`=1 during cycles N+1 … N+`RST_CYCLES`. The first `cpu_en`=1 cycle is N+`RST_CYCLES`+1.
- Stop latency: `cpu_en` drops in the same cycle the condition appears. The state and flags update at the next edge.
- `max_cycles`=K (K≠0): exactly K enabled cycles, then TIMEOUT. This assumes no halt occurs first.
- Halt and breakpoint on the same PC: DONE; `bp_hit` stays 0.
- `reset` mid-run aborts immediately at the next edge. `cpu_en` is low from that edge on.
- Inputs are sampled level-sensitively at each edge. Pulses of one cycle are sufficient.

## Structure
- Package `run_ctrl_pkg` holds:
  - state encodings: IDLE=0, RESET=1, RUN=2, STEP=3, PAUSE=4, DONE=5, TIMEOUT=6, in 3 bits.
  - default `HALT_ADDR`.
- Sub-module `bp_match`: NUM_BP parallel equality compares with enable, producing the `NUM_BP` hit vector and an OR-reduced `any`.
- Top holds the FSM, the reset-length counter, the cycle counter and the latches.

## Test plan
- Halt run: program loops, then jumps to 0xFC after 37 instructions; `max_cycles`=500 → DONE with `cycle_count`=37, `halt_pc`=0xFC, `cpu_en`=0 while pc=0xFC.
- Timeout: infinite loop, `max_cycles`=500 → TIMEOUT with `cycle_count`=500; `cpu_en` was 1 for exactly 500 cycles.
- Breakpoint: `bp_en`=2'b01, `bp_addr[0]`=0x10 → PAUSE with `bp_hit`=01, `halt_pc`=0x10. Then `resume` → next enabled cycle executes 0x10 and does not re-pause.
- Single step from PAUSE at 0x10: `step` → one `cpu_en`=1 cycle, back to PAUSE, pc=0x14, `cycle_count` +1.
- Priorities: `bp_addr[1]`=0xFC enabled → DONE with `bp_hit`=0. Also `max_cycles`=0 with no halt: runs 65535 cycles and the count saturates, with no TIMEOUT.
- Reset/restart:
  - `reset` asserted mid-RUN → all outputs at reset values on the next cycle.
  - `start` in DONE → 2 cycles of `cpu_reset`, then RUN with the counter at 0.
